// File: rtl/fifo_multi_ch.sv
// rtl/fifo_multi_ch.sv - NUM_CH independent circular-buffer FIFOs with status, sticky error flags and registered or FWFT read port
module fifo_multi_ch #(
  parameter int W_WIDTH   = 32,
  parameter int FIFO_SIZE = 64,
  parameter int NUM_CH    = 4,
  parameter int AF_LEVEL  = FIFO_SIZE - 4,
  parameter int AE_LEVEL  = 4,
  parameter int FWFT      = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_CH-1:0]                         wr_en,
  input  logic [NUM_CH*W_WIDTH-1:0]                 data_in,
  input  logic [NUM_CH-1:0]                         rd_en,
  input  logic                                      clr_err,
  output logic [NUM_CH*W_WIDTH-1:0]                 data_out,
  output logic [NUM_CH-1:0]                         data_valid,
  output logic [NUM_CH-1:0]                         full,
  output logic [NUM_CH-1:0]                         empty,
  output logic [NUM_CH-1:0]                         almost_full,
  output logic [NUM_CH-1:0]                         almost_empty,
  output logic [NUM_CH*($clog2(FIFO_SIZE)+1)-1:0]   count,
  output logic [NUM_CH-1:0]                         overflow,
  output logic [NUM_CH-1:0]                         underflow
);

  localparam int PW = $clog2(FIFO_SIZE);
  localparam int CW = PW + 1;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [W_WIDTH-1:0] mem [FIFO_SIZE];
      logic [PW-1:0]      wr_ptr;
      logic [PW-1:0]      rd_ptr;
      logic [CW-1:0]      cnt;
      logic               is_full;
      logic               is_empty;
      logic               rd_acc;
      logic               wr_acc;
      logic               ovf;
      logic               udf;
      logic [W_WIDTH-1:0] dout;
      logic               dval;

      assign is_full  = (cnt == CW'(FIFO_SIZE));
      assign is_empty = (cnt == '0);
      // A pop frees a slot in the same cycle, so a full channel may still accept a write alongside it.
      assign rd_acc   = rd_en[c] && !is_empty;
      assign wr_acc   = wr_en[c] && (!is_full || rd_acc);

      always_ff @(posedge clk) begin
        if (wr_acc) begin
          mem[wr_ptr] <= data_in[c*W_WIDTH +: W_WIDTH];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
          ovf    <= 1'b0;
          udf    <= 1'b0;
        end else begin
          if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
          if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
          case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
          endcase
          // A new error event takes priority over a simultaneous clear.
          if (wr_en[c] && !wr_acc) ovf <= 1'b1;
          else if (clr_err)        ovf <= 1'b0;
          if (rd_en[c] && is_empty) udf <= 1'b1;
          else if (clr_err)         udf <= 1'b0;
        end
      end

      if (FWFT != 0) begin : g_fwft
        assign dout = is_empty ? '0 : mem[rd_ptr];
        assign dval = !is_empty;
      end else begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dout <= '0;
            dval <= 1'b0;
          end else if (rd_acc) begin
            dout <= mem[rd_ptr];
            dval <= 1'b1;
          end else begin
            dout <= '0;
            dval <= 1'b0;
          end
        end
      end

      assign data_out[c*W_WIDTH +: W_WIDTH] = dout;
      assign data_valid[c]                  = dval;
      assign full[c]                        = is_full;
      assign empty[c]                       = is_empty;
      assign almost_full[c]                 = (cnt >= CW'(AF_LEVEL));
      assign almost_empty[c]                = (cnt <= CW'(AE_LEVEL));
      assign count[c*CW +: CW]              = cnt;
      assign overflow[c]                    = ovf;
      assign underflow[c]                   = udf;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_multi_ch.sv
// tb/tb_fifo_multi_ch.sv - directed self-checking bench for fifo_multi_ch (registered and FWFT read ports)
module tb_fifo_multi_ch;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   wr_en, rd_en;
  logic [N*W-1:0] data_in, data_out;
  logic [N-1:0]   data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [N*CW-1:0] count;
  logic           clr_err;

  logic           rst2_n;
  logic [1:0]     wr2, rd2;
  logic [31:0]    din2, dout2;
  logic [1:0]     dval2, full2, empty2, af2, ae2, ovf2, udf2;
  logic [7:0]     cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_multi_ch u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_multi_ch #(.W_WIDTH(16), .FIFO_SIZE(8), .NUM_CH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst2_n), .wr_en(wr2), .data_in(din2), .rd_en(rd2),
    .clr_err(1'b0), .data_out(dout2), .data_valid(dval2), .full(full2),
    .empty(empty2), .almost_full(af2), .almost_empty(ae2),
    .count(cnt2), .overflow(ovf2), .underflow(udf2)
  );

  function automatic logic [CW-1:0] cnt_of(input int c);
    return count[c*CW +: CW];
  endfunction

  function automatic logic [W-1:0] dout_of(input int c);
    return data_out[c*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; clr_err = 1'b0; data_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; idle(); wr2 = '0; rd2 = '0; din2 = '0;
    tick(); tick();
    checks++; if (empty !== 4'hF || full !== 4'h0) begin errors++;
      $display("FAIL reset_empty_full: empty=%h full=%h required F/0", empty, full); end
    checks++; if (count !== '0 || data_valid !== '0 || data_out !== '0) begin errors++;
      $display("FAIL reset_count_out: count=%h dval=%h dout=%h required 0", count, data_valid, data_out); end
    checks++; if (almost_empty !== 4'hF || almost_full !== 4'h0 || overflow !== 0 || underflow !== 0) begin errors++;
      $display("FAIL reset_flags: ae=%h af=%h ovf=%h udf=%h required F/0/0/0", almost_empty, almost_full, overflow, underflow); end
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_ch0();
    for (int i = 0; i < 64; i++) begin
      wr_en = 4'b0001; data_in = '0; data_in[W-1:0] = i;
      tick();
      if (i == 3 || i == 4) begin
        checks++; if (almost_empty[0] !== (i == 3)) begin errors++;
          $display("FAIL fill_ae count=%0d: got %b required %b", i + 1, almost_empty[0], (i == 3)); end
      end
      if (i == 58 || i == 59) begin
        checks++; if (almost_full[0] !== (i == 59)) begin errors++;
          $display("FAIL fill_af count=%0d: got %b required %b", i + 1, almost_full[0], (i == 59)); end
      end
    end
    checks++; if (full[0] !== 1'b1 || cnt_of(0) !== 7'd64) begin errors++;
      $display("FAIL fill_full: full=%b count=%0d required 1/64", full[0], cnt_of(0)); end
    data_in[W-1:0] = 32'hDEAD;
    tick();
    checks++; if (overflow[0] !== 1'b1 || cnt_of(0) !== 7'd64) begin errors++;
      $display("FAIL fill_overflow: ovf=%b count=%0d required 1/64", overflow[0], cnt_of(0)); end
    wr_en = '0; rd_en = 4'b0001;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++; if (dout_of(0) !== i || data_valid[0] !== 1'b1) begin errors++;
        $display("FAIL fill_drain[%0d]: got %h v=%b required %h v=1", i, dout_of(0), data_valid[0], i); end
    end
    rd_en = '0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (overflow[0] !== 1'b0 || empty[0] !== 1'b1 || data_valid[0] !== 1'b0) begin errors++;
      $display("FAIL fill_clear: ovf=%b empty=%b v=%b required 0/1/0", overflow[0], empty[0], data_valid[0]); end
  endtask

  task automatic test_read_latency();
    idle(); wr_en = 4'b0100; data_in[2*W +: W] = 32'hA5A5A5A5;
    tick();
    idle(); rd_en = 4'b0100;
    tick();
    rd_en = '0;
    checks++; if (dout_of(2) !== 32'hA5A5A5A5 || data_valid !== 4'b0100) begin errors++;
      $display("FAIL latency_data: dout=%h dval=%b required a5a5a5a5/0100", dout_of(2), data_valid); end
    checks++; if (dout_of(0) !== 0 || dout_of(1) !== 0 || dout_of(3) !== 0) begin errors++;
      $display("FAIL latency_others: dout=%h required other channels 0", data_out); end
    tick();
    checks++; if (data_valid !== 4'b0000 || data_out !== '0) begin errors++;
      $display("FAIL latency_drop: dval=%b dout=%h required 0/0", data_valid, data_out); end
  endtask

  task automatic test_full_rw();
    idle();
    for (int i = 0; i < 64; i++) begin
      wr_en = 4'b0010; data_in[W +: W] = 100 + i;
      tick();
    end
    data_in[W +: W] = 32'h1234; wr_en = 4'b0010; rd_en = 4'b0010;
    tick();
    checks++; if (cnt_of(1) !== 7'd64 || dout_of(1) !== 32'd100 || overflow[1] !== 1'b0) begin errors++;
      $display("FAIL full_rw: count=%0d dout=%h ovf=%b required 64/64/0", cnt_of(1), dout_of(1), overflow[1]); end
    checks++; if (cnt_of(0) !== 0 || cnt_of(2) !== 0 || cnt_of(3) !== 0) begin errors++;
      $display("FAIL full_rw_isolation: count=%h required others 0", count); end
    wr_en = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++; if (dout_of(1) !== ((i == 63) ? 32'h1234 : 101 + i)) begin errors++;
        $display("FAIL full_rw_drain[%0d]: got %h required %h", i, dout_of(1), (i == 63) ? 32'h1234 : 101 + i); end
    end
    rd_en = '0;
    tick();
  endtask

  task automatic test_empty_rw();
    idle(); wr_en = 4'b1000; rd_en = 4'b1000; data_in[3*W +: W] = 32'h55;
    tick();
    idle();
    checks++; if (underflow[3] !== 1'b1 || cnt_of(3) !== 7'd1 || data_valid[3] !== 1'b0) begin errors++;
      $display("FAIL empty_rw: udf=%b count=%0d v=%b required 1/1/0", underflow[3], cnt_of(3), data_valid[3]); end
    rd_en = 4'b1000;
    tick();
    rd_en = '0;
    checks++; if (dout_of(3) !== 32'h55 || data_valid[3] !== 1'b1) begin errors++;
      $display("FAIL empty_rw_read: dout=%h v=%b required 55/1", dout_of(3), data_valid[3]); end
    clr_err = 1'b1;
    tick();
    checks++; if (underflow[3] !== 1'b0) begin errors++;
      $display("FAIL empty_rw_clr: udf=%b required 0", underflow[3]); end
    rd_en = 4'b1000;
    tick();
    checks++; if (underflow[3] !== 1'b1) begin errors++;
      $display("FAIL clr_vs_event: udf=%b required 1", underflow[3]); end
    rd_en = '0;
    tick();
    clr_err = 1'b0;
    checks++; if (underflow !== 4'b0000 || overflow !== 4'b0000) begin errors++;
      $display("FAIL clr_final: udf=%b ovf=%b required 0/0", underflow, overflow); end
  endtask

  task automatic test_wrap();
    idle();
    for (int i = 0; i < 2; i++) begin
      wr_en = 4'b0001; data_in[W-1:0] = 32'h1000 + i;
      tick();
    end
    for (int n = 0; n < 200; n++) begin
      wr_en = 4'b0001; rd_en = 4'b0001; data_in[W-1:0] = 32'h1000 + n + 2;
      tick();
      checks++; if (dout_of(0) !== 32'h1000 + n || cnt_of(0) !== 7'd2) begin errors++;
        $display("FAIL wrap[%0d]: dout=%h count=%0d required %h/2", n, dout_of(0), cnt_of(0), 32'h1000 + n); end
    end
    wr_en = '0;
    tick(); tick();
    rd_en = '0;
    checks++; if (dout_of(0) !== 32'h1000 + 201 || empty[0] !== 1'b1) begin errors++;
      $display("FAIL wrap_tail: dout=%h empty=%b required %h/1", dout_of(0), empty[0], 32'h1000 + 201); end
    checks++; if (overflow !== 0 || underflow !== 0) begin errors++;
      $display("FAIL wrap_flags: ovf=%b udf=%b required 0/0", overflow, underflow); end
  endtask

  task automatic test_fwft_reset();
    wr2 = '0; rd2 = '0; din2 = '0;
    checks++; if (dval2 !== 2'b00 || dout2 !== '0) begin errors++;
      $display("FAIL fwft_empty: dval=%b dout=%h required 0/0", dval2, dout2); end
    wr2 = 2'b01; din2 = 32'h0011;
    tick();
    checks++; if (dval2 !== 2'b01 || dout2 !== 32'h0011) begin errors++;
      $display("FAIL fwft_first: dval=%b dout=%h required 01/00000011", dval2, dout2); end
    din2 = 32'h0022; tick();
    din2 = 32'h0033; tick();
    wr2 = '0; rd2 = 2'b01;
    tick();
    checks++; if (dout2 !== 32'h0022 || cnt2[3:0] !== 4'd2) begin errors++;
      $display("FAIL fwft_pop: dout=%h count=%0d required 00000022/2", dout2, cnt2[3:0]); end
    #2 rst2_n = 1'b0;
    #1;
    checks++; if (dval2 !== 2'b00 || dout2 !== '0 || empty2 !== 2'b11 || cnt2 !== '0) begin errors++;
      $display("FAIL fwft_reset: dval=%b dout=%h empty=%b count=%h required 0/0/11/0", dval2, dout2, empty2, cnt2); end
    rd2 = '0;
    tick();
    rst2_n = 1'b1;
    tick();
    checks++; if (dval2 !== 2'b00 || empty2 !== 2'b11 || ovf2 !== 0 || udf2 !== 0 || full2 !== 0) begin errors++;
      $display("FAIL fwft_post_reset: dval=%b empty=%b ovf=%b udf=%b full=%b", dval2, empty2, ovf2, udf2, full2); end
  endtask

  initial begin
    test_reset();
    test_fill_ch0();
    test_read_latency();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_fwft_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_multi_ch.md
FIFO_MULTI_CH -- requirements
Module: fifo_multi_ch

Interface
REQ-001 Parameter W_WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter FIFO_SIZE, default 64, depth per channel in words (power of two, >=4).
REQ-003 Parameter NUM_CH, default 4, number of independent channels (>=1).
REQ-004 Parameter AF_LEVEL, default FIFO_SIZE-4, almost_full threshold in words.
REQ-005 Parameter AE_LEVEL, default 4, almost_empty threshold in words.
REQ-006 Parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 wr_en  input  NUM_CH  per-channel write request.
REQ-010 data_in  input  NUM_CH*W_WIDTH  write data; channel c occupies bits [c*W_WIDTH +: W_WIDTH].
REQ-011 rd_en  input  NUM_CH  per-channel read (pop) request.
REQ-012 clr_err  input  1  synchronous clear of all overflow/underflow flags.
REQ-013 data_out  output  NUM_CH*W_WIDTH  read data, same packing as data_in.
REQ-014 data_valid  output  NUM_CH  per-channel data_out qualifier.
REQ-015 full, empty, almost_full, almost_empty  output  NUM_CH each  per-channel status.
REQ-016 count  output  NUM_CH*($clog2(FIFO_SIZE)+1)  per-channel occupancy, packed as data_in.
REQ-017 overflow, underflow  output  NUM_CH each  sticky per-channel error flags.

Function
REQ-018 Each channel SHALL be a fully independent circular buffer; no channel's activity SHALL affect another's state.
REQ-019 Each channel SHALL hold exactly FIFO_SIZE words; full SHALL assert when count==FIFO_SIZE, empty when count==0.
REQ-020 Read and write pointers SHALL be $clog2(FIFO_SIZE) bits and wrap naturally from FIFO_SIZE-1 to 0.
REQ-021 Read accepted = rd_en && !empty, evaluated on pre-edge state.
REQ-022 Write accepted = wr_en && (!full || read accepted in the same cycle); full with simultaneous read+write keeps count at FIFO_SIZE.
REQ-023 Empty with simultaneous wr_en+rd_en: write accepted, read rejected, count becomes 1, underflow set.
REQ-024 count SHALL update on the edge after the request: +1 write only, -1 read only, unchanged both or neither.
REQ-025 almost_full SHALL equal (count >= AF_LEVEL); almost_empty SHALL equal (count <= AE_LEVEL); both derived from registered count, no added latency.
REQ-026 FWFT=0: accepted read SHALL drive head word on data_out with data_valid=1 one cycle later; otherwise data_out=0, data_valid=0.
REQ-027 FWFT=1: data_out SHALL show head word and data_valid=1 whenever !empty; data_out=0, data_valid=0 when empty; rd_en pops head, next word visible the following cycle.
REQ-028 overflow[c] SHALL set on a rejected write (wr_en while full without accepted read); underflow[c] SHALL set on rd_en while empty; both remain set until clr_err or reset.
REQ-029 clr_err SHALL clear flags on the next edge; an error event in the same cycle as clr_err SHALL win (flag set).
REQ-030 Rejected writes/reads SHALL leave pointers, count and stored data unchanged.

Reset
REQ-031 rst_n low SHALL immediately clear pointers, count, data_out, data_valid, overflow, underflow, full, almost_full; empty=1, almost_empty=1, on all channels.
REQ-032 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared, and no stale word SHALL appear on data_out after reset.
REQ-033 Release of rst_n SHALL be synchronised by the surrounding design; first accepted operation is on the first rising edge with rst_n high.

Verification
REQ-034 Defaults, ch0: write 64 words 0..63 -> full[0]=1, count=64, almost_full from count 60; 65th write -> overflow[0]=1, count stays 64.
REQ-035 FWFT=0, ch2: write 0xA5A5A5A5, read next cycle -> data_out ch2=0xA5A5A5A5, data_valid[2]=1 exactly one cycle, then 0; other channels' outputs stay 0.
REQ-036 Ch1 full, wr_en+rd_en together with 0x1234 -> count stays 64, head popped, 0x1234 read back as 64th word after draining.
REQ-037 Ch3 empty, wr_en+rd_en with 0x55 -> underflow[3]=1, count=1, next read returns 0x55; clr_err -> underflow[3]=0.
REQ-038 Pointer wrap: 200 interleaved writes/reads on ch0 at occupancy 1..3 -> data in order, no flag errors.
REQ-039 FWFT=1: write 3 words, assert rst_n low mid-read -> all outputs at reset values immediately, empty=1, data_valid=0.
